mm_verify_respond_rx: RTL and testbench

- Receive-side mPacket classifier for the 802.3br MAC Merge sublayer.
- Monitors the GMII-style receive octet stream from the PHY.
- Detects well-formed verify (SMD-V) and respond (SMD-R) mPackets and raises the rcv_v / rcv_r variables consumed by the respond and verify state diagrams.
- Holds each flag until the consuming state diagram acknowledges it; counts malformed verify/respond mPackets.

---
 rtl/mm_verify_respond_rx.sv | 145 ++++++++++++++
 tb/tb_mm_verify_respond_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mm_verify_respond_rx.sv
// Receive-side verify/respond mPacket classifier for the MAC Merge sublayer.
// Latency: rcv_v/rcv_r rise the cycle after rx_dv falls on a well-formed mPacket.
// Backpressure: none; the PHY octet stream cannot be stalled, flags hold until cleared.
module mm_verify_respond_rx #(
  parameter logic [7:0] SMD_V        = 8'h07,
  parameter logic [7:0] SMD_R        = 8'h19,
  parameter int         MIN_PREAMBLE = 6,
  parameter int         BODY_LEN     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_enable,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        rcv_v,
  input  logic        rcv_v_clr,
  output logic        rcv_r,
  input  logic        rcv_r_clr,
  output logic [15:0] vr_err_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_BODY     = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;

  localparam logic [3:0]  MIN_PRE_C   = 4'(MIN_PREAMBLE);
  localparam logic [6:0]  BODY_LEN_C  = 7'(BODY_LEN);
  localparam logic [6:0]  BODY_MAX_C  = 7'(BODY_LEN + 1);
  localparam logic [6:0]  DATA_LEN_C  = 7'(BODY_LEN - 4);
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // Non-reflected CRC-32 register fed one octet LSB first; over data+FCS it
  // lands on the fixed residue, so no separate FCS compare is needed.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [2:0]  state;
  logic [3:0]  pre_cnt;
  logic [6:0]  body_cnt;
  logic [31:0] crc;
  logic        bad;
  logic        is_resp;

  logic frame_end;
  logic frame_ok;
  logic set_v;
  logic set_r;

  // The verdict is taken on the edge where BODY first sees rx_dv low, so the
  // flag shows one cycle after the fall; CHECK then absorbs the IPG cycle.
  always_comb begin
    frame_end = (state == ST_BODY) && !rx_dv;
    frame_ok  = frame_end && (body_cnt == BODY_LEN_C) && !bad && (crc == CRC_RESIDUE);
    set_v     = frame_ok && p_enable && !is_resp;
    set_r     = frame_ok && p_enable && is_resp;
  end

  // Frame-parsing state machine with preamble/body counters and running CRC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pre_cnt  <= 4'd0;
      body_cnt <= 7'd0;
      crc      <= 32'hFFFFFFFF;
      bad      <= 1'b0;
      is_resp  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rxd == 8'h55 && !rx_er) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_er) begin
            state <= ST_DROP;
          end else if (rxd == 8'h55) begin
            if (pre_cnt != 4'd15) pre_cnt <= pre_cnt + 4'd1;
          end else if ((rxd == SMD_V || rxd == SMD_R) && pre_cnt >= MIN_PRE_C) begin
            state    <= ST_BODY;
            is_resp  <= (rxd == SMD_R);
            crc      <= 32'hFFFFFFFF;
            body_cnt <= 7'd0;
            bad      <= 1'b0;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_BODY: begin
          if (rx_dv) begin
            crc <= crc_next(crc, rxd);
            if (body_cnt != BODY_MAX_C) body_cnt <= body_cnt + 7'd1;
            if (rx_er || (rxd != 8'h00 && body_cnt < DATA_LEN_C)) bad <= 1'b1;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: state <= ST_IDLE;
        ST_DROP:  if (!rx_dv) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Level flags: a set beats a same-cycle clear; repeated sets do not queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcv_v <= 1'b0;
      rcv_r <= 1'b0;
    end else begin
      if (set_v)          rcv_v <= 1'b1;
      else if (rcv_v_clr) rcv_v <= 1'b0;
      if (set_r)          rcv_r <= 1'b1;
      else if (rcv_r_clr) rcv_r <= 1'b0;
    end
  end

  // Saturating count of malformed verify/respond mPackets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vr_err_count <= 16'd0;
    end else if (frame_end && !frame_ok && vr_err_count != 16'hFFFF) begin
      vr_err_count <= vr_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mm_verify_respond_rx.sv
// Directed bench for the verify/respond mPacket classifier.
// Frames are built from hand-chosen vectors with an FCS from a reflected CRC-32 model.
// Outputs are sampled on the falling clock edge, inputs driven there too.
module tb_mm_verify_respond_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_enable = 1'b1;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rcv_v;
  logic        rcv_v_clr = 1'b0;
  logic        rcv_r;
  logic        rcv_r_clr = 1'b0;
  logic [15:0] vr_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frame [$];

  mm_verify_respond_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .p_enable     (p_enable),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rxd          (rxd),
    .rcv_v        (rcv_v),
    .rcv_v_clr    (rcv_v_clr),
    .rcv_r        (rcv_r),
    .rcv_r_clr    (rcv_r_clr),
    .vr_err_count (vr_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Builds preamble, SMD and n_data body octets (all zero except one optional
  // poke), then appends an FCS from a reflected CRC-32 over the body data.
  task automatic make_frame(input int n_pre, input logic [7:0] smd, input int n_data,
                            input int poke_pos, input logic [7:0] poke_val, input bit add_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    frame.delete();
    for (int i = 0; i < n_pre; i++) frame.push_back(8'h55);
    frame.push_back(smd);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_data; i++) begin
      b = (i == poke_pos) ? poke_val : 8'h00;
      frame.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    if (add_fcs) begin
      c = ~c;
      frame.push_back(c[7:0]);
      frame.push_back(c[15:8]);
      frame.push_back(c[23:16]);
      frame.push_back(c[31:24]);
    end
  endtask

  // Drives the frame, raising rx_er at frame index er_at, then drops rx_dv
  // and returns before the edge that sees rx_dv low.
  task automatic send_frame(input int er_at);
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      rx_dv = 1'b1;
      rx_er = (i == er_at);
      rxd   = frame[i];
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Sends a frame, lets it finish, and checks flags and counter afterwards.
  task automatic frame_result(input string tag, input int er_at, input logic exp_v,
                              input logic exp_r, input logic [15:0] exp_cnt);
    send_frame(er_at);
    @(negedge clk);
    check({tag, "_rcv_v"}, 32'(rcv_v), 32'(exp_v));
    check({tag, "_rcv_r"}, 32'(rcv_r), 32'(exp_r));
    check({tag, "_cnt"}, 32'(vr_err_count), 32'(exp_cnt));
    idle(2);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_rcv_v", 32'(rcv_v), 32'd0);
    check("rst_rcv_r", 32'(rcv_r), 32'd0);
    check("rst_cnt", 32'(vr_err_count), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Valid verify: flag exactly one cycle after rx_dv falls
    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    send_frame(-1);
    check("v_before_edge", 32'(rcv_v), 32'd0);
    @(negedge clk);
    check("v_set", 32'(rcv_v), 32'd1);
    check("v_rcv_r", 32'(rcv_r), 32'd0);
    check("v_cnt", 32'(vr_err_count), 32'd0);
    rcv_v_clr = 1'b1;
    @(negedge clk);
    rcv_v_clr = 1'b0;
    check("v_clr", 32'(rcv_v), 32'd0);
    idle(2);

    // Valid respond, then set and clear in the same cycle
    make_frame(7, 8'h19, 60, -1, 8'h00, 1'b1);
    frame_result("r_first", -1, 1'b0, 1'b1, 16'd0);
    send_frame(-1);
    rcv_r_clr = 1'b1;
    @(negedge clk);
    rcv_r_clr = 1'b0;
    check("r_set_wins", 32'(rcv_r), 32'd1);
    check("r_v_indep", 32'(rcv_v), 32'd0);
    idle(2);

    // Minimum preamble of exactly 6 is accepted
    make_frame(6, 8'h07, 60, -1, 8'h00, 1'b1);
    frame_result("pre6", -1, 1'b1, 1'b1, 16'd0);
    rcv_v_clr = 1'b1;
    @(negedge clk);
    rcv_v_clr = 1'b0;
    check("pre6_clr", 32'(rcv_v), 32'd0);
    idle(1);

    // Short preamble of 5 is dropped silently
    make_frame(5, 8'h07, 60, -1, 8'h00, 1'b1);
    frame_result("pre5", -1, 1'b0, 1'b1, 16'd0);

    // Malformed body: nonzero data octet, short and long bodies
    make_frame(7, 8'h07, 60, 30, 8'h01, 1'b1);
    frame_result("data_nz", -1, 1'b0, 1'b1, 16'd1);
    make_frame(7, 8'h07, 59, -1, 8'h00, 1'b1);
    frame_result("len63", -1, 1'b0, 1'b1, 16'd2);
    make_frame(7, 8'h07, 61, -1, 8'h00, 1'b1);
    frame_result("len65", -1, 1'b0, 1'b1, 16'd3);

    // Corrupted final FCS octet, then rx_er on body octet 10
    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'hFF;
    frame_result("bad_fcs", -1, 1'b0, 1'b1, 16'd4);
    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    frame_result("rx_er", 8 + 10, 1'b0, 1'b1, 16'd5);

    // Ordinary and SMD-S frames are ignored
    make_frame(7, 8'hD5, 64, 5, 8'hA3, 1'b0);
    frame_result("sfd", -1, 1'b0, 1'b1, 16'd5);
    make_frame(7, 8'hE6, 60, -1, 8'h00, 1'b1);
    frame_result("smd_s", -1, 1'b0, 1'b1, 16'd5);

    // Valid verify while disabled: discarded, and rcv_r stays set
    p_enable = 1'b0;
    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    frame_result("p_dis", -1, 1'b0, 1'b1, 16'd5);
    p_enable = 1'b1;

    // Reset mid-frame, released while the frame is still arriving
    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      rx_dv = 1'b1;
      rxd   = frame[i];
      if (i == 8 + 20) begin
        reset_n = 1'b0;
        #1;
        check("mid_rst_rcv_r", 32'(rcv_r), 32'd0);
        check("mid_rst_rcv_v", 32'(rcv_v), 32'd0);
        check("mid_rst_cnt", 32'(vr_err_count), 32'd0);
      end
      if (i == 8 + 21) reset_n = 1'b1;
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rxd   = 8'h00;
    @(negedge clk);
    check("post_rst_rcv_v", 32'(rcv_v), 32'd0);
    check("post_rst_cnt", 32'(vr_err_count), 32'd0);
    idle(2);

    make_frame(7, 8'h07, 60, -1, 8'h00, 1'b1);
    frame_result("after_rst", -1, 1'b1, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
